// File: rtl/dma_job_scheduler.sv
// Job sequencer between the host job queue and the DMA engine register port.
// Programs the engine per queued job, watches for completion or timeout, and coalesces completions into host interrupts.
module dma_job_scheduler #(
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_src_base,
    input  logic [31:0] cfg_dest_base,
    input  logic        cfg_valid,
    input  logic [31:0] job_size,
    input  logic        job_valid,
    output logic        job_ready,
    output logic [31:0] reg_wr_data,
    output logic [5:0]  reg_wr_en,
    input  logic        eng_intr,
    input  logic [3:0]  coal_thresh,
    input  logic        irq_ack,
    output logic        host_intr,
    output logic [15:0] done_cnt,
    output logic        busy,
    output logic        err
);

    localparam int          AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);
    localparam logic [31:0] WD_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, CFG_SRC, CFG_DST, CFG_TAIL, CFG_HEAD, READY, DROP,
        LD_SIZE, LD_HEAD, START, WAIT, CLEAR, ABORT, HALT
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   fifo_mem [QDEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [31:0]   src_base_reg, dest_base_reg;
    logic [31:0]   head_acc_reg;
    logic [31:0]   wd_reg;
    logic [3:0]    pending_reg;
    logic [15:0]   done_cnt_reg;
    logic          configured_reg;
    logic          err_reg;
    logic          host_intr_reg;

    logic          fifo_full, fifo_empty, push, pop;
    logic          cfg_accept, completion;
    logic [31:0]   head_job, head_sum;
    logic [3:0]    coal_eff;

    assign fifo_full  = (count_reg == FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign job_ready  = ~fifo_full;
    // fifo_full is registered, so a same-cycle pop never frees room for a push
    assign push       = job_valid & ~fifo_full;
    assign pop        = (state_reg == CLEAR) || (state_reg == DROP) || (state_reg == ABORT);
    assign head_job   = fifo_mem[rd_ptr_reg];
    assign head_sum   = head_acc_reg + head_job;
    assign completion = (state_reg == CLEAR) || (state_reg == DROP);
    assign cfg_accept = cfg_valid &&
                        ((state_reg == IDLE) || (state_reg == READY) || (state_reg == HALT));
    assign coal_eff   = (coal_thresh == 4'h0) ? 4'h1 : coal_thresh;

    assign host_intr  = host_intr_reg;
    assign done_cnt   = done_cnt_reg;
    assign err        = err_reg;
    assign busy       = !((state_reg == IDLE) || (state_reg == READY) || (state_reg == HALT));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= job_size;
        end
    end

    always_comb begin
        state_next  = state_reg;
        reg_wr_en   = 6'b000000;
        reg_wr_data = 32'h0;
        case (state_reg)
            IDLE: if (cfg_valid) state_next = CFG_SRC;
            CFG_SRC: begin
                reg_wr_en   = 6'b000001;
                reg_wr_data = src_base_reg;
                state_next  = CFG_DST;
            end
            CFG_DST: begin
                reg_wr_en   = 6'b000010;
                reg_wr_data = dest_base_reg;
                state_next  = CFG_TAIL;
            end
            CFG_TAIL: begin
                reg_wr_en  = 6'b000100;
                state_next = CFG_HEAD;
            end
            CFG_HEAD: begin
                reg_wr_en  = 6'b001000;
                state_next = READY;
            end
            READY: begin
                if (cfg_valid) begin
                    state_next = CFG_SRC;
                end else if (configured_reg && !fifo_empty) begin
                    state_next = (head_job == 32'h0) ? DROP : LD_SIZE;
                end
            end
            DROP: state_next = READY;
            LD_SIZE: begin
                reg_wr_en   = 6'b010000;
                reg_wr_data = head_job;
                state_next  = LD_HEAD;
            end
            LD_HEAD: begin
                reg_wr_en   = 6'b001000;
                reg_wr_data = head_sum;
                state_next  = START;
            end
            START: begin
                reg_wr_en   = 6'b100000;
                reg_wr_data = 32'h1;
                state_next  = WAIT;
            end
            // completion beats the watchdog when both land in the same cycle
            WAIT: begin
                if (eng_intr) begin
                    state_next = CLEAR;
                end else if (wd_reg == WD_LAST) begin
                    state_next = ABORT;
                end
            end
            CLEAR: begin
                reg_wr_en  = 6'b100000;
                state_next = READY;
            end
            ABORT: begin
                reg_wr_en  = 6'b100000;
                state_next = HALT;
            end
            HALT: if (cfg_valid) state_next = CFG_SRC;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            src_base_reg   <= 32'h0;
            dest_base_reg  <= 32'h0;
            head_acc_reg   <= 32'h0;
            wd_reg         <= 32'h0;
            pending_reg    <= 4'h0;
            done_cnt_reg   <= 16'h0;
            configured_reg <= 1'b0;
            err_reg        <= 1'b0;
            host_intr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (cfg_accept) begin
                src_base_reg  <= cfg_src_base;
                dest_base_reg <= cfg_dest_base;
            end

            if (state_reg == CFG_HEAD) begin
                head_acc_reg   <= 32'h0;
                configured_reg <= 1'b1;
            end else if (state_reg == LD_HEAD) begin
                head_acc_reg <= head_sum;
            end

            if (state_reg == START) begin
                wd_reg <= 32'h0;
            end else if (state_reg == WAIT) begin
                wd_reg <= wd_reg + 32'h1;
            end

            if (state_reg == ABORT) err_reg <= 1'b1;

            if (completion) begin
                done_cnt_reg <= done_cnt_reg + 16'h1;
                if (irq_ack) begin
                    pending_reg <= 4'h1;
                end else if (pending_reg != 4'hF) begin
                    pending_reg <= pending_reg + 4'h1;
                end
            end else if (irq_ack) begin
                pending_reg <= 4'h0;
            end

            host_intr_reg <= (pending_reg >= coal_eff) ||
                             ((pending_reg != 4'h0) && fifo_empty && (state_reg == READY));
        end
    end

endmodule
